// File: rtl/fht_frame_loader.sv
// Streaming input stage for fht_top: accepts ADC samples, sign-extends them and
// scatters each frame round-robin over the RAM banks, then hands the frame to the core.
module fht_frame_loader #(
  parameter int D_BIT    = 18,
  parameter int ADC_BIT  = 17,
  parameter int A_BIT    = 8,
  parameter int NUM_BANK = 4
) (
  input  logic                iCLK,
  input  logic                iRESET,
  input  logic                iVALID,
  output logic                oREADY,
  input  logic [ADC_BIT-1:0]  iDATA,
  input  logic                iMODE_BITREV,
  output logic [NUM_BANK-1:0] oWE,
  output logic [A_BIT-1:0]    oADDR_WR,
  output logic [D_BIT-1:0]    oDATA,
  output logic                oSTART,
  input  logic                iRDY,
  output logic                oBUSY,
  output logic                oFRAME_DONE
);

  localparam int BANK_SIZE = 2 ** A_BIT;
  localparam int FRAME_LEN = NUM_BANK * BANK_SIZE;
  localparam int K_BIT     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [K_BIT-1:0] K_LAST = K_BIT'(FRAME_LEN - 1);

  typedef enum logic [1:0] {LOAD, FIRE, WAIT_ACK, WAIT_DONE} state_t;

  state_t              state;
  logic [K_BIT-1:0]    k;
  logic                mode;
  logic                eff_mode;
  logic                accept;
  logic [A_BIT-1:0]    row;
  logic [A_BIT-1:0]    addr;
  logic [NUM_BANK-1:0] we_next;

  assign oREADY   = (state == LOAD);
  assign accept   = iVALID & oREADY;
  // The first sample of a frame uses the live mode pin; later samples use the latched copy.
  assign eff_mode = (k == '0) ? iMODE_BITREV : mode;
  assign row      = A_BIT'(k / NUM_BANK);
  assign we_next  = NUM_BANK'(1) << (k % NUM_BANK);

  always_comb begin
    addr = row;
    if (eff_mode) begin
      for (int i = 0; i < A_BIT; i++) addr[i] = row[A_BIT-1-i];
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state       <= LOAD;
      k           <= '0;
      mode        <= 1'b0;
      oWE         <= '0;
      oADDR_WR    <= '0;
      oDATA       <= '0;
      oSTART      <= 1'b0;
      oBUSY       <= 1'b0;
      oFRAME_DONE <= 1'b0;
    end else begin
      oWE         <= '0;
      oSTART      <= 1'b0;
      oFRAME_DONE <= 1'b0;
      case (state)
        LOAD: begin
          if (accept) begin
            oWE      <= we_next;
            oADDR_WR <= addr;
            oDATA    <= D_BIT'($signed(iDATA));
            oBUSY    <= 1'b1;
            if (k == '0) mode <= iMODE_BITREV;
            // The start pulse lands in the same cycle as the last sample's write.
            if (k == K_LAST) begin
              k      <= '0;
              oSTART <= 1'b1;
              state  <= FIRE;
            end else begin
              k <= k + K_BIT'(1);
            end
          end
        end
        FIRE: state <= WAIT_ACK;
        WAIT_ACK: begin
          if (!iRDY) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (iRDY) begin
            oFRAME_DONE <= 1'b1;
            oBUSY       <= 1'b0;
            state       <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fht_frame_loader.sv
// Self-checking bench for fht_frame_loader with a small 4-bank, 8-row frame.
module tb_fht_frame_loader;

  localparam int D_BIT    = 18;
  localparam int ADC_BIT  = 17;
  localparam int A_BIT    = 3;
  localparam int NUM_BANK = 4;
  localparam int FRAME    = 32;

  logic                iCLK = 1'b0;
  logic                iRESET;
  logic                iVALID;
  logic                oREADY;
  logic [ADC_BIT-1:0]  iDATA;
  logic                iMODE_BITREV;
  logic [NUM_BANK-1:0] oWE;
  logic [A_BIT-1:0]    oADDR_WR;
  logic [D_BIT-1:0]    oDATA;
  logic                oSTART;
  logic                iRDY;
  logic                oBUSY;
  logic                oFRAME_DONE;

  int checks = 0;
  int passed = 0;

  fht_frame_loader #(
    .D_BIT(D_BIT), .ADC_BIT(ADC_BIT), .A_BIT(A_BIT), .NUM_BANK(NUM_BANK)
  ) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iVALID(iVALID), .oREADY(oREADY),
    .iDATA(iDATA), .iMODE_BITREV(iMODE_BITREV), .oWE(oWE), .oADDR_WR(oADDR_WR),
    .oDATA(oDATA), .oSTART(oSTART), .iRDY(iRDY), .oBUSY(oBUSY),
    .oFRAME_DONE(oFRAME_DONE)
  );

  always #5 iCLK = ~iCLK;

  // Reference model: sample k goes to bank k%4, row k/4, optionally bit-reversed.
  function automatic logic [NUM_BANK-1:0] exp_we(int k);
    return NUM_BANK'(1 << (k % NUM_BANK));
  endfunction

  function automatic logic [A_BIT-1:0] exp_addr(int k, bit m);
    int r = k / NUM_BANK;
    int rev = 0;
    if (!m) return A_BIT'(r);
    for (int i = 0; i < A_BIT; i++) begin
      rev = rev * 2 + r % 2;
      r = r / 2;
    end
    return A_BIT'(rev);
  endfunction

  function automatic logic [D_BIT-1:0] exp_data(logic [ADC_BIT-1:0] d);
    int v = int'(d);
    if (v >= (1 << (ADC_BIT - 1))) v = v - (1 << ADC_BIT);
    return D_BIT'(v);
  endfunction

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  // Plays the FHT core: acknowledge the start, then report completion.
  task automatic run_core();
    iVALID = 1'b0;
    iRDY = 1'b0;
    step();
    step();
    iRDY = 1'b1;
    step();
  endtask

  task automatic test_reset();
    iRESET = 1'b1; iVALID = 1'b1; iDATA = 17'($urandom); iMODE_BITREV = 1'b0; iRDY = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if ({oWE, oADDR_WR, oDATA} !== '0)
        $display("[TB] FAIL reset_write_outs: got we=%0h addr=%0h data=%0h required 0", oWE, oADDR_WR, oDATA);
      else passed++;
      checks++; if ({oSTART, oBUSY, oFRAME_DONE} !== 3'b000)
        $display("[TB] FAIL reset_ctrl_outs: got start/busy/done=%b required 000", {oSTART, oBUSY, oFRAME_DONE});
      else passed++;
    end
    iRESET = 1'b0; iVALID = 1'b0;
    step();
    checks++; if (oREADY !== 1'b1)
      $display("[TB] FAIL ready_after_reset: got %b required 1", oREADY);
    else passed++;
  endtask

  task automatic test_natural();
    iMODE_BITREV = 1'b0; iRDY = 1'b1;
    for (int k = 0; k < FRAME; k++) begin
      iVALID = 1'b1; iDATA = 17'(k);
      checks++; if (oREADY !== 1'b1)
        $display("[TB] FAIL nat_ready k=%0d: got %b required 1", k, oREADY);
      else passed++;
      step();
      checks++; if (oWE !== exp_we(k))
        $display("[TB] FAIL nat_we k=%0d: got %b required %b", k, oWE, exp_we(k));
      else passed++;
      checks++; if (oADDR_WR !== exp_addr(k, 1'b0))
        $display("[TB] FAIL nat_addr k=%0d: got %0d required %0d", k, oADDR_WR, exp_addr(k, 1'b0));
      else passed++;
      checks++; if (oDATA !== exp_data(17'(k)))
        $display("[TB] FAIL nat_data k=%0d: got %0h required %0h", k, oDATA, exp_data(17'(k)));
      else passed++;
      checks++; if (oSTART !== (k == FRAME - 1))
        $display("[TB] FAIL nat_start k=%0d: got %b required %b", k, oSTART, k == FRAME - 1);
      else passed++;
      checks++; if (oBUSY !== 1'b1)
        $display("[TB] FAIL nat_busy k=%0d: got %b required 1", k, oBUSY);
      else passed++;
    end
    run_core();
    checks++; if ({oFRAME_DONE, oBUSY} !== 2'b10)
      $display("[TB] FAIL nat_done: got done/busy=%b required 10", {oFRAME_DONE, oBUSY});
    else passed++;
    step();
  endtask

  task automatic test_bitrev();
    iRDY = 1'b1;
    for (int k = 0; k < FRAME; k++) begin
      iVALID = 1'b1; iDATA = 17'($urandom);
      iMODE_BITREV = (k < 10) ? 1'b1 : 1'b0;
      step();
      checks++; if (oWE !== exp_we(k))
        $display("[TB] FAIL rev_we k=%0d: got %b required %b", k, oWE, exp_we(k));
      else passed++;
      checks++; if (oADDR_WR !== exp_addr(k, 1'b1))
        $display("[TB] FAIL rev_addr k=%0d: got %0d required %0d", k, oADDR_WR, exp_addr(k, 1'b1));
      else passed++;
    end
    run_core();
    checks++; if (oFRAME_DONE !== 1'b1)
      $display("[TB] FAIL rev_done: got %b required 1", oFRAME_DONE);
    else passed++;
    step();
  endtask

  task automatic test_sign_ext();
    int k = 0;
    bit m = 1'($urandom_range(0, 1));
    logic [A_BIT-1:0] last_addr = '0;
    logic [D_BIT-1:0] last_data = '0;
    logic [ADC_BIT-1:0] d;
    iRDY = 1'b1;
    for (int it = 0; it < 400 && k < FRAME; it++) begin
      bit v = (k < 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
      d = (k == 0) ? 17'h10000 : (k == 1) ? 17'h0FFFF : 17'($urandom);
      iVALID = v; iDATA = d;
      iMODE_BITREV = (k == 0) ? m : 1'($urandom_range(0, 1));
      step();
      if (v) begin
        checks++; if (oWE !== exp_we(k) || oADDR_WR !== exp_addr(k, m))
          $display("[TB] FAIL sx_write k=%0d: got we=%b addr=%0d required we=%b addr=%0d", k, oWE, oADDR_WR, exp_we(k), exp_addr(k, m));
        else passed++;
        checks++; if (oDATA !== exp_data(d))
          $display("[TB] FAIL sx_data k=%0d: got %0h required %0h", k, oDATA, exp_data(d));
        else passed++;
        if (k == 0) begin
          checks++; if (oDATA !== 18'h30000)
            $display("[TB] FAIL sx_neg: got %0h required 30000", oDATA);
          else passed++;
        end
        if (k == 1) begin
          checks++; if (oDATA !== 18'h0FFFF)
            $display("[TB] FAIL sx_pos: got %0h required 0ffff", oDATA);
          else passed++;
        end
        checks++; if (oSTART !== (k == FRAME - 1))
          $display("[TB] FAIL sx_start k=%0d: got %b required %b", k, oSTART, k == FRAME - 1);
        else passed++;
        last_addr = exp_addr(k, m);
        last_data = exp_data(d);
        k++;
      end else begin
        checks++; if (oWE !== '0 || oADDR_WR !== last_addr || oDATA !== last_data || oSTART !== 1'b0)
          $display("[TB] FAIL sx_gap_hold k=%0d: got we=%b addr=%0d data=%0h required we=0 addr=%0d data=%0h", k, oWE, oADDR_WR, oDATA, last_addr, last_data);
        else passed++;
      end
    end
    checks++; if (k != FRAME)
      $display("[TB] FAIL sx_frame_len: got %0d samples required %0d", k, FRAME);
    else passed++;
    run_core();
    checks++; if (oFRAME_DONE !== 1'b1)
      $display("[TB] FAIL sx_done: got %b required 1", oFRAME_DONE);
    else passed++;
    step();
  endtask

  task automatic test_handshake();
    int done_seen = 0;
    iRDY = 1'b1; iMODE_BITREV = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      iVALID = 1'b1; iDATA = 17'($urandom);
      step();
    end
    checks++; if (oSTART !== 1'b1)
      $display("[TB] FAIL hs_start: got %b required 1", oSTART);
    else passed++;
    iVALID = 1'b1;
    for (int c = 0; c < 60; c++) begin
      int n = c + 1;
      if (c == 2) iRDY = 1'b0;
      if (c == 52) begin iRDY = 1'b1; iVALID = 1'b0; end
      step();
      if (oFRAME_DONE === 1'b1) done_seen++;
      if (n < 53) begin
        checks++; if (oREADY !== 1'b0 || oWE !== '0 || oBUSY !== 1'b1 || oSTART !== 1'b0 || oFRAME_DONE !== 1'b0)
          $display("[TB] FAIL hs_hold n=%0d: got ready=%b we=%b busy=%b start=%b done=%b required 0 0 1 0 0", n, oREADY, oWE, oBUSY, oSTART, oFRAME_DONE);
        else passed++;
      end else if (n == 53) begin
        checks++; if ({oFRAME_DONE, oBUSY} !== 2'b10)
          $display("[TB] FAIL hs_done: got done/busy=%b required 10", {oFRAME_DONE, oBUSY});
        else passed++;
      end else begin
        checks++; if (oREADY !== 1'b1 || oFRAME_DONE !== 1'b0)
          $display("[TB] FAIL hs_ready_after: got ready=%b done=%b required 1 0", oREADY, oFRAME_DONE);
        else passed++;
        break;
      end
    end
    checks++; if (done_seen != 1)
      $display("[TB] FAIL hs_done_count: got %0d required 1", done_seen);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    int k = 0;
    bit m = 1'($urandom_range(0, 1));
    logic [ADC_BIT-1:0] d;
    iRDY = 1'b1;
    for (int it = 0; it < 400 && k < 17; it++) begin
      bit v = ($urandom_range(0, 2) != 0);
      iVALID = v; iDATA = 17'($urandom); iMODE_BITREV = m;
      step();
      if (v) k++;
    end
    iRESET = 1'b1; iVALID = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (oWE !== '0 || oSTART !== 1'b0 || oBUSY !== 1'b0 || oFRAME_DONE !== 1'b0)
        $display("[TB] FAIL rst_mid: got we=%b start=%b busy=%b done=%b required all 0", oWE, oSTART, oBUSY, oFRAME_DONE);
      else passed++;
    end
    iRESET = 1'b0; iVALID = 1'b0;
    step();
    checks++; if (oREADY !== 1'b1 || oSTART !== 1'b0 || oFRAME_DONE !== 1'b0)
      $display("[TB] FAIL rst_release: got ready=%b start=%b done=%b required 1 0 0", oREADY, oSTART, oFRAME_DONE);
    else passed++;
    k = 0;
    for (int it = 0; it < 400 && k < FRAME; it++) begin
      bit v = ($urandom_range(0, 3) != 0);
      d = 17'($urandom);
      iVALID = v; iDATA = d;
      iMODE_BITREV = (k == 0) ? m : 1'($urandom_range(0, 1));
      step();
      if (v) begin
        checks++; if (oWE !== exp_we(k) || oADDR_WR !== exp_addr(k, m) || oDATA !== exp_data(d))
          $display("[TB] FAIL rst_next_write k=%0d: got we=%b addr=%0d data=%0h required we=%b addr=%0d data=%0h", k, oWE, oADDR_WR, oDATA, exp_we(k), exp_addr(k, m), exp_data(d));
        else passed++;
        checks++; if (oSTART !== (k == FRAME - 1))
          $display("[TB] FAIL rst_next_start k=%0d: got %b required %b", k, oSTART, k == FRAME - 1);
        else passed++;
        k++;
      end else begin
        checks++; if (oWE !== '0 || oSTART !== 1'b0)
          $display("[TB] FAIL rst_next_gap k=%0d: got we=%b start=%b required 0 0", k, oWE, oSTART);
        else passed++;
      end
    end
    run_core();
    checks++; if ({oFRAME_DONE, oBUSY} !== 2'b10)
      $display("[TB] FAIL rst_next_done: got done/busy=%b required 10", {oFRAME_DONE, oBUSY});
    else passed++;
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_natural();
    test_bitrev();
    test_sign_ext();
    test_handshake();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
